// File: rtl/mii_rx_deframer_if.sv
// mii_rx_deframer_if: received byte stream from the MII deframer.
// No backpressure; the slave takes every beat that has m_valid high.
interface mii_rx_deframer_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_err;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    output m_err
  );

  modport slave (
    input m_data,
    input m_valid,
    input m_last,
    input m_err
  );
endinterface

// File: rtl/mii_rx_deframer.sv
// mii_rx_deframer: MII rx nibbles to bytes, strips preamble/SFD/FCS, checks CRC/len.
// Optional MII_RX_STATS_EN adds saturating good_frames/bad_frames counters.
module mii_rx_deframer #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] phy_rxd,
  input  logic       phy_rx_dv,
  input  logic       phy_rx_er,
`ifdef MII_RX_STATS_EN
  output logic [15:0] good_frames,
  output logic [15:0] bad_frames,
`endif
  mii_rx_deframer_if.master m
);

  localparam logic [31:0] CRC_RES = 32'hDEBB20E3;
  localparam logic [10:0] MIN_L = 11'(MIN_FRAME_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    DROP
  } state_t;

  state_t          state;
  logic [3:0]      rxd_q;
  logic            dv_q;
  logic            er_q;
  logic            armed;
  logic            seen5;
  logic            phase;
  logic [3:0]      low_q;
  logic            bad;
  logic [10:0]     cnt;
  logic [31:0]     crc;
  logic [4:0][7:0] line;
  logic [7:0]      byte_w;

  function automatic logic [31:0] crc_next(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign byte_w = {rxd_q, low_q};

  // Input register; dv_q resets high so a frame already on the wire
  // at reset release is never mistaken for an idle gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_q <= 4'h0;
      dv_q  <= 1'b1;
      er_q  <= 1'b0;
    end else begin
      rxd_q <= phy_rxd;
      dv_q  <= phy_rx_dv;
      er_q  <= phy_rx_er;
    end
  end

  // Deframing FSM with registered stream outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      seen5     <= 1'b0;
      phase     <= 1'b0;
      low_q     <= 4'h0;
      bad       <= 1'b0;
      cnt       <= 11'd0;
      crc       <= 32'h0;
      line      <= '0;
      m.m_data  <= 8'h00;
      m.m_valid <= 1'b0;
      m.m_last  <= 1'b0;
      m.m_err   <= 1'b0;
    end else begin
      m.m_valid <= 1'b0;
      m.m_last  <= 1'b0;
      m.m_err   <= 1'b0;
      if (!dv_q)
        armed <= 1'b1;
      unique case (state)
        IDLE: begin
          if (dv_q && armed) begin
            state <= PREAMBLE;
            seen5 <= (rxd_q == 4'h5);
          end
        end
        PREAMBLE: begin
          if (!dv_q) begin
            state <= IDLE;
          end else if (rxd_q == 4'h5) begin
            seen5 <= 1'b1;
          end else if (rxd_q == 4'hD && seen5) begin
            state <= PAYLOAD;
            phase <= 1'b0;
            cnt   <= 11'd0;
            crc   <= 32'hFFFFFFFF;
            bad   <= 1'b0;
          end else begin
            state <= DROP;
          end
        end
        PAYLOAD: begin
          if (cnt > MAX_L) begin
            m.m_data  <= 8'h00;
            m.m_valid <= 1'b1;
            m.m_last  <= 1'b1;
            m.m_err   <= 1'b1;
            state     <= DROP;
          end else if (!dv_q) begin
            state <= IDLE;
            if (cnt != 11'd0) begin
              m.m_valid <= 1'b1;
              m.m_last  <= 1'b1;
              m.m_data  <= (cnt < 11'd5) ? 8'h00 : line[4];
              m.m_err   <= bad | er_q | phase |
                           (cnt < MIN_L) | (crc != CRC_RES);
            end
          end else begin
            if (er_q)
              bad <= 1'b1;
            if (!phase) begin
              low_q <= rxd_q;
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              crc   <= crc_next(crc, byte_w);
              cnt   <= cnt + 11'd1;
              line  <= {line[3:0], byte_w};
              if (cnt >= 11'd5) begin
                m.m_data  <= line[4];
                m.m_valid <= 1'b1;
              end
            end
          end
        end
        DROP: begin
          if (!dv_q)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MII_RX_STATS_EN
  // Saturating per-frame outcome counters, bumped on each final beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      good_frames <= 16'h0;
      bad_frames  <= 16'h0;
    end else if (m.m_valid && m.m_last) begin
      if (m.m_err) begin
        if (bad_frames != 16'hFFFF)
          bad_frames <= bad_frames + 16'h1;
      end else begin
        if (good_frames != 16'hFFFF)
          good_frames <= good_frames + 16'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mii_rx_deframer.sv
// tb_mii_rx_deframer: table-driven frame vectors plus reset-mid-frame sequence.
// Build with +define+MII_RX_STATS_EN to also check the frame counters.
module tb_mii_rx_deframer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] phy_rxd = 4'h0;
  logic       phy_rx_dv = 1'b0;
  logic       phy_rx_er = 1'b0;
`ifdef MII_RX_STATS_EN
  logic [15:0] good_frames;
  logic [15:0] bad_frames;
`endif

  mii_rx_deframer_if m_if ();

  mii_rx_deframer dut (
    .clk       (clk),
    .rst       (rst),
    .phy_rxd   (phy_rxd),
    .phy_rx_dv (phy_rx_dv),
    .phy_rx_er (phy_rx_er),
`ifdef MII_RX_STATS_EN
    .good_frames (good_frames),
    .bad_frames  (bad_frames),
`endif
    .m         (m_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n_data;
    bit fcs;
    int flip;
    int er_at;
    bit bad_pre;
    bit odd;
    int exp_beats;
    bit exp_err;
    bit zero_last;
  } vec_t;

  vec_t       vt[14];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mon_d[$];
  bit         mon_l[$];
  bit         mon_e[$];
  logic [7:0] sent[$];

  always @(negedge clk) begin
    if (m_if.m_valid) begin
      mon_d.push_back(m_if.m_data);
      mon_l.push_back(m_if.m_last);
      mon_e.push_back(m_if.m_err);
    end
  end

  function automatic logic [31:0] crc_tb(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s vec %0d actual %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic dv, input logic er);
    @(posedge clk);
    #1;
    phy_rxd   = d;
    phy_rx_dv = dv;
    phy_rx_er = er;
  endtask

  task automatic build(input vec_t v, input int idx, output logic [7:0] fr[$]);
    logic [31:0] c;
    logic [7:0]  b;
    fr = {};
    c  = 32'hFFFFFFFF;
    for (int i = 0; i < v.n_data; i++) begin
      b = 8'((i * 13 + idx * 29 + 1) & 255);
      fr.push_back(b);
      c = crc_tb(c, b);
    end
    if (v.fcs) begin
      c = ~c;
      fr.push_back(c[7:0]);
      fr.push_back(c[15:8]);
      fr.push_back(c[23:16]);
      fr.push_back(c[31:24]);
    end
    if (v.flip >= 0)
      fr[v.flip] = fr[v.flip] ^ 8'h08;
  endtask

  task automatic send_pre(input bit bad_pre);
    for (int k = 0; k < 15; k++) begin
      drive(4'h5, 1'b1, 1'b0);
      if (bad_pre && k == 10)
        drive(4'h7, 1'b1, 1'b0);
    end
    drive(4'hD, 1'b1, 1'b0);
  endtask

  task automatic check_frame(input vec_t v, input int idx);
    int nb;
    int nlast;
    int bad;
    logic [7:0] e;
    nb = mon_d.size();
    nlast = 0;
    bad = 0;
    foreach (mon_l[i])
      if (mon_l[i]) nlast++;
    chk("beats", idx, nb, v.exp_beats);
    chk("last_cnt", idx, nlast, (v.exp_beats > 0) ? 1 : 0);
    if (v.exp_beats > 0) begin
      chk("last_pos", idx, (nb > 0) ? mon_l[nb-1] : 0, 1);
      chk("err", idx, (nb > 0) ? mon_e[nb-1] : 0, v.exp_err);
      for (int i = 0; i < nb && i < v.exp_beats; i++) begin
        e = (i == v.exp_beats - 1 && v.zero_last) ? 8'h00 : sent[i];
        if (mon_d[i] !== e) bad++;
      end
      chk("data", idx, bad, 0);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] fr[$];
    build(v, idx, fr);
    sent  = fr;
    mon_d = {};
    mon_l = {};
    mon_e = {};
    send_pre(v.bad_pre);
    foreach (fr[j]) begin
      drive(fr[j][3:0], 1'b1, (v.er_at == j) ? 1'b1 : 1'b0);
      drive(fr[j][7:4], 1'b1, 1'b0);
    end
    if (v.odd)
      drive(4'hA, 1'b1, 1'b0);
    repeat (12) drive(4'h0, 1'b0, 1'b0);
    check_frame(v, idx);
  endtask

  task automatic reset_mid_frame();
    logic [7:0] fr[$];
    vec_t v;
    int n;
    v = '{60, 1'b1, -1, -1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    build(v, 20, fr);
    send_pre(1'b0);
    n = 0;
    foreach (fr[j]) begin
      for (int h = 0; h < 2; h++) begin
        if (n == 40) rst = 1'b0;
        drive(h ? fr[j][7:4] : fr[j][3:0], 1'b1, 1'b0);
        if (n == 41) begin
          @(negedge clk);
          chk("rst_mid_valid", 20, m_if.m_valid, 0);
          chk("rst_mid_data", 20, m_if.m_data, 0);
        end
        if (n == 42) begin
          rst   = 1'b1;
          mon_d = {};
          mon_l = {};
          mon_e = {};
        end
        n++;
      end
    end
    repeat (12) drive(4'h0, 1'b0, 1'b0);
    sent = {};
    check_frame(v, 20);
  endtask

  initial begin
    vt[0]  = '{60,   1'b1, -1, -1, 1'b0, 1'b0, 60,   1'b0, 1'b0};
    vt[1]  = '{298,  1'b1, -1, -1, 1'b0, 1'b0, 298,  1'b0, 1'b0};
    vt[2]  = '{60,   1'b1, 10, -1, 1'b0, 1'b0, 60,   1'b1, 1'b0};
    vt[3]  = '{60,   1'b1, -1, 20, 1'b0, 1'b0, 60,   1'b1, 1'b0};
    vt[4]  = '{59,   1'b1, -1, -1, 1'b0, 1'b0, 59,   1'b1, 1'b0};
    vt[5]  = '{60,   1'b1, -1, -1, 1'b1, 1'b0, 0,    1'b0, 1'b0};
    vt[6]  = '{60,   1'b1, -1, -1, 1'b0, 1'b0, 60,   1'b0, 1'b0};
    vt[7]  = '{3,    1'b0, -1, -1, 1'b0, 1'b0, 1,    1'b1, 1'b1};
    vt[8]  = '{0,    1'b0, -1, -1, 1'b0, 1'b0, 0,    1'b0, 1'b0};
    vt[9]  = '{60,   1'b1, -1, -1, 1'b0, 1'b1, 60,   1'b1, 1'b0};
    vt[10] = '{1514, 1'b1, -1, -1, 1'b0, 1'b0, 1514, 1'b0, 1'b0};
    vt[11] = '{1515, 1'b1, -1, -1, 1'b0, 1'b0, 1515, 1'b1, 1'b1};
    vt[12] = '{4,    1'b0, -1, -1, 1'b0, 1'b0, 1,    1'b1, 1'b1};
    vt[13] = '{5,    1'b0, -1, -1, 1'b0, 1'b0, 1,    1'b1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", -1, m_if.m_valid, 0);
    chk("reset_last", -1, m_if.m_last, 0);
    chk("reset_err", -1, m_if.m_err, 0);
    chk("reset_data", -1, m_if.m_data, 0);
    #1;
    rst = 1'b1;
    repeat (4) drive(4'h0, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++)
      run_vec(vt[i], i);

    reset_mid_frame();
    run_vec(vt[0], 21);
`ifdef MII_RX_STATS_EN
    chk("good_frames", 21, good_frames, 1);
    chk("bad_frames", 21, bad_frames, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mii_rx_deframer.md
Name: mii_rx_deframer

Overview:
Receive-side MII deframer in the 100M Ethernet MAC. It consumes the 4-bit MII receive stream produced by the PHY or host model (phy_rxd/phy_rx_dv/phy_rx_er) and strips the preamble and SFD. It assembles nibbles into bytes, checks CRC-32 and length, removes the FCS, and presents each frame as a byte stream with a last/error marker to the downstream Ethernet/IP parser. There is no backpressure; the consumer must accept one beat whenever m_valid is high.

Parameters:
MIN_FRAME_LEN, 64, minimum legal frame length in bytes (DA through FCS inclusive)
MAX_FRAME_LEN, 1518, maximum legal frame length in bytes (DA through FCS inclusive)

Ports:
clk  input  1  system clock; MII receive signals are sampled on its rising edge
rst  input  1  asynchronous, active-low reset
phy_rxd  input  4  MII receive nibble; low nibble of each byte first
phy_rx_dv  input  1  MII receive data valid
phy_rx_er  input  1  MII receive error
m_data  output  8  frame byte, DA first, FCS excluded
m_valid  output  1  m_data is valid this cycle (single-cycle pulse per byte)
m_last  output  1  final beat of frame, qualified by m_valid
m_err  output  1  frame bad; qualified by m_valid && m_last

Behaviour:
- Reset: the reset is asynchronous and active-low. While asserted, m_data=0, m_valid=0, m_last=0, m_err=0, state=IDLE, all counters, CRC and delay line are cleared, and armed=0.
- Input stage: phy_rxd, phy_rx_dv and phy_rx_er are registered once. All FSM logic uses the registered copies (rxd_q, dv_q, er_q).
- armed: set when dv_q=0 is observed. This prevents the block from locking onto a frame that was already in progress when reset released.
- IDLE:
  - dv_q=1 with armed=1 -> PREAMBLE.
  - dv_q=1 with armed=0 -> remain in IDLE.
- PREAMBLE:
  - rxd_q=0x5 -> stay and set seen5.
  - rxd_q=0xD with seen5 -> PAYLOAD, nibble phase 0, byte count 0, CRC=0xFFFFFFFF.
  - Any other nibble -> DROP.
  - dv_q=0 -> IDLE with no output.
- PAYLOAD:
  - Phase 0 latches the low nibble. Phase 1 completes the byte {rxd_q, low}.
  - Each completed byte updates the CRC (reflected CRC-32, polynomial 0xEDB88320, LSB first, one byte per update), increments the byte count, and shifts into a 5-byte delay line.
  - When the delay line already holds 5 bytes, the oldest byte is emitted the same cycle the new byte arrives (m_valid=1, m_last=0). Output latency is therefore 5 bytes, so 4 FCS bytes plus 1 held byte are retained.
  - er_q=1 at any point sets the sticky bad flag.
  - Byte count exceeding MAX_FRAME_LEN: next cycle emit m_data=0x00 with m_valid=1, m_last=1, m_err=1, then go to DROP. This event takes precedence over a dv_q fall in the same cycle.
- End of frame: dv_q falls while in PAYLOAD.
  - Next cycle emit the held byte (delay line position 4) with m_last=1.
  - m_err=1 if any of: bad flag set; odd nibble phase (dangling nibble); byte count < MIN_FRAME_LEN; CRC register != 0xDEBB20E3.
  - Then go to IDLE.
- Short frames:
  - 1 to 4 bytes: emit a single beat with m_data=0x00, m_last=1, m_err=1.
  - 0 bytes after SFD: no output.
- DROP: produces no output. dv_q=0 -> IDLE.
- Beat spacing: m_valid beats are at least 2 cycles apart. The final beat follows the previous beat by at least 1 cycle.
- Reset asserted mid-frame: the frame is silently discarded and no m_last is emitted. The block waits for dv low before accepting the next frame.
- Resource: a 32-bit CRC, an 11-bit byte counter, and a 5x8 delay line.

Optional Feature:
MII_RX_STATS_EN:
- Defined: adds output ports good_frames[15:0] and bad_frames[15:0]. These are saturating counters, incremented on every m_last beat according to m_err, and cleared by rst.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Valid 64-byte ARP reply frame (7x0x55, 0xD5, 60 data bytes, correct FCS) -> exactly 60 m_valid beats matching the data bytes, m_last on beat 60, m_err=0.
- Valid 302-byte UDP frame (8-byte preamble/SFD, 298 data bytes, FCS) -> 298 beats, m_last=1, m_err=0; good_frames=1 when MII_RX_STATS_EN is defined.
- Same 64-byte frame with one payload bit flipped -> 60 beats, final beat m_err=1.
- phy_rx_er pulsed for one cycle mid-payload -> last beat m_err=1. A further 63-byte frame with valid CRC -> m_err=1 (runt).
- Preamble nibble 0x7 inserted before the SFD -> no m_valid for the whole frame. The immediately following valid frame is received correctly.
- rst asserted for 3 cycles in the middle of a frame and released while phy_rx_dv is still high -> no output for the remainder of that frame. The next valid frame is received with m_err=0.
